// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - multi-port register file with write bypass and pending (scoreboard) bits
//
// Purpose:
//   DEPTH x WIDTH register file with N_RD combinational read ports, one write
//   port and one reserve port. Each register carries a pending bit that is set
//   when a producer is issued (Reserve) and cleared when its result is written
//   back (RegWrite). A registered PendingCount tracks the number of set bits.
//   Index ZERO_REG reads as zero and ignores writes/reserves; setting
//   ZERO_REG >= DEPTH disables that behaviour.
//
// Ports:
//   clk             - clock, all state updates on the rising edge
//   reset           - synchronous, active-low reset
//   ReadRegister    - [N_RD][AW] read address per port
//   ReadData        - [N_RD][WIDTH] read data per port (write-bypassed)
//   ReadPending     - [N_RD] addressed register awaits an outstanding write
//   RegWrite        - write enable
//   WriteRegister   - write address
//   WriteData       - write data
//   Reserve         - mark ReserveRegister pending
//   ReserveRegister - register to mark pending
//   PendingCount    - number of pending registers

module regfile_sb #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 32,
  parameter int N_RD     = 2,
  parameter int ZERO_REG = 31,
  localparam int AW      = $clog2(DEPTH),
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_RD-1:0][AW-1:0]     ReadRegister,
  output logic [N_RD-1:0][WIDTH-1:0]  ReadData,
  output logic [N_RD-1:0]             ReadPending,
  input  logic                        RegWrite,
  input  logic [AW-1:0]               WriteRegister,
  input  logic [WIDTH-1:0]            WriteData,
  input  logic                        Reserve,
  input  logic [AW-1:0]               ReserveRegister,
  output logic [CW-1:0]               PendingCount
);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0] pend_q;
  logic [DEPTH-1:0] pend_d;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;

  // One-hot decoded write and reserve strobes. Decoding against each legal
  // index means out-of-range addresses (non-power-of-2 DEPTH) and the zero
  // register simply produce no strobe.
  logic [DEPTH-1:0] we_vec;
  logic [DEPTH-1:0] rs_vec;
  logic             cnt_inc;
  logic             cnt_dec;

  always_comb begin
    we_vec = '0;
    rs_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      we_vec[i] = RegWrite && (WriteRegister == AW'(i)) && (i != ZERO_REG);
      rs_vec[i] = Reserve && (ReserveRegister == AW'(i)) && (i != ZERO_REG);
    end
  end

  // Next state. Reserve is applied after the write clear so a same-register
  // reserve+write leaves the bit set.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      regs_d[i] = we_vec[i] ? WriteData : regs_q[i];
    end
    pend_d = (pend_q & ~we_vec) | rs_vec;

    // Incremental popcount: a reserve adds one only on a clear bit; a write
    // removes one only on a set bit that is not simultaneously re-reserved.
    cnt_inc = |(rs_vec & ~pend_q);
    cnt_dec = |(we_vec & pend_q & ~rs_vec);
    count_d = count_q + CW'(cnt_inc) - CW'(cnt_dec);
  end

  // Read ports. A same-cycle write to the addressed register forwards its
  // data and hides the pending bit it is about to clear; the reserve input
  // deliberately has no combinational effect here.
  always_comb begin
    for (int k = 0; k < N_RD; k++) begin
      ReadData[k]    = '0;
      ReadPending[k] = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        if ((ReadRegister[k] == AW'(i)) && (i != ZERO_REG)) begin
          ReadData[k]    = we_vec[i] ? WriteData : regs_q[i];
          ReadPending[k] = pend_q[i] & ~we_vec[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      pend_q  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
      pend_q  <= pend_d;
      count_q <= count_d;
    end
  end

  assign PendingCount = count_q;

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - table-driven self-checking bench for regfile_sb

module tb_regfile_sb;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0][4:0]  rr;
  logic [1:0][63:0] rd;
  logic [1:0]       rp;
  logic             we;
  logic [4:0]       wa;
  logic [63:0]      wd;
  logic             rs;
  logic [4:0]       rsa;
  logic [5:0]       cnt;

  logic             b_reset;
  logic [1:0][2:0]  b_rr;
  logic [1:0][15:0] b_rd;
  logic [1:0]       b_rp;
  logic             b_we;
  logic [2:0]       b_wa;
  logic [15:0]      b_wd;
  logic             b_rs;
  logic [2:0]       b_rsa;
  logic [2:0]       b_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  regfile_sb #(.WIDTH(64), .DEPTH(32), .N_RD(2), .ZERO_REG(31)) dut (
    .clk(clk), .reset(reset), .ReadRegister(rr), .ReadData(rd), .ReadPending(rp),
    .RegWrite(we), .WriteRegister(wa), .WriteData(wd), .Reserve(rs),
    .ReserveRegister(rsa), .PendingCount(cnt)
  );

  // Non-power-of-2 depth with the hardwired-zero register disabled.
  regfile_sb #(.WIDTH(16), .DEPTH(6), .N_RD(2), .ZERO_REG(6)) dut_b (
    .clk(clk), .reset(b_reset), .ReadRegister(b_rr), .ReadData(b_rd), .ReadPending(b_rp),
    .RegWrite(b_we), .WriteRegister(b_wa), .WriteData(b_wd), .Reserve(b_rs),
    .ReserveRegister(b_rsa), .PendingCount(b_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic        rs;
    logic [4:0]  rsa;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [63:0] d0;
    logic [63:0] d1;
    logic        p0;
    logic        p1;
    logic [5:0]  cnt;
  } vec_t;

  vec_t tbl[22];

  initial begin
    //           rst   we    wa     wd                      rs    rsa    a0     a1     d0                      d1                      p0    p1    cnt
    tbl[0]  = '{1'b1, 1'b0, 5'd0,  64'h0,                  1'b0, 5'd0,  5'd0,  5'd30, 64'h0,                  64'h0,                  1'b0, 1'b0, 6'd0};
    tbl[1]  = '{1'b1, 1'b1, 5'd5,  64'hDEAD_BEEF,          1'b0, 5'd0,  5'd5,  5'd5,  64'hDEAD_BEEF,          64'hDEAD_BEEF,          1'b0, 1'b0, 6'd0};
    tbl[2]  = '{1'b1, 1'b0, 5'd0,  64'h0,                  1'b0, 5'd0,  5'd5,  5'd5,  64'hDEAD_BEEF,          64'hDEAD_BEEF,          1'b0, 1'b0, 6'd0};
    tbl[3]  = '{1'b1, 1'b1, 5'd7,  64'h1234,               1'b0, 5'd0,  5'd7,  5'd5,  64'h1234,               64'hDEAD_BEEF,          1'b0, 1'b0, 6'd0};
    tbl[4]  = '{1'b1, 1'b1, 5'd31, 64'hFFFF,               1'b0, 5'd0,  5'd31, 5'd7,  64'h0,                  64'h1234,               1'b0, 1'b0, 6'd0};
    tbl[5]  = '{1'b1, 1'b0, 5'd0,  64'h0,                  1'b1, 5'd31, 5'd31, 5'd31, 64'h0,                  64'h0,                  1'b0, 1'b0, 6'd0};
    tbl[6]  = '{1'b1, 1'b0, 5'd0,  64'h0,                  1'b1, 5'd3,  5'd3,  5'd4,  64'h0,                  64'h0,                  1'b0, 1'b0, 6'd0};
    tbl[7]  = '{1'b1, 1'b0, 5'd0,  64'h0,                  1'b1, 5'd4,  5'd3,  5'd4,  64'h0,                  64'h0,                  1'b1, 1'b0, 6'd1};
    tbl[8]  = '{1'b1, 1'b0, 5'd0,  64'h0,                  1'b0, 5'd0,  5'd3,  5'd4,  64'h0,                  64'h0,                  1'b1, 1'b1, 6'd2};
    tbl[9]  = '{1'b1, 1'b1, 5'd3,  64'hA,                  1'b0, 5'd0,  5'd3,  5'd4,  64'hA,                  64'h0,                  1'b0, 1'b1, 6'd2};
    tbl[10] = '{1'b1, 1'b1, 5'd4,  64'hB,                  1'b1, 5'd4,  5'd4,  5'd3,  64'hB,                  64'hA,                  1'b0, 1'b0, 6'd1};
    tbl[11] = '{1'b1, 1'b0, 5'd0,  64'h0,                  1'b0, 5'd0,  5'd4,  5'd3,  64'hB,                  64'hA,                  1'b1, 1'b0, 6'd1};
    tbl[12] = '{1'b1, 1'b0, 5'd0,  64'h0,                  1'b1, 5'd4,  5'd4,  5'd3,  64'hB,                  64'hA,                  1'b1, 1'b0, 6'd1};
    tbl[13] = '{1'b1, 1'b1, 5'd5,  64'h77,                 1'b1, 5'd6,  5'd5,  5'd6,  64'h77,                 64'h0,                  1'b0, 1'b0, 6'd1};
    tbl[14] = '{1'b1, 1'b1, 5'd6,  64'h66,                 1'b1, 5'd8,  5'd6,  5'd8,  64'h66,                 64'h0,                  1'b0, 1'b0, 6'd2};
    tbl[15] = '{1'b1, 1'b0, 5'd0,  64'h0,                  1'b0, 5'd0,  5'd6,  5'd8,  64'h66,                 64'h0,                  1'b0, 1'b1, 6'd2};
    tbl[16] = '{1'b1, 1'b1, 5'd9,  64'h55,                 1'b0, 5'd0,  5'd9,  5'd4,  64'h55,                 64'hB,                  1'b0, 1'b1, 6'd2};
    tbl[17] = '{1'b1, 1'b0, 5'd0,  64'h0,                  1'b1, 5'd9,  5'd9,  5'd8,  64'h55,                 64'h0,                  1'b0, 1'b1, 6'd2};
    tbl[18] = '{1'b0, 1'b1, 5'd9,  64'h99,                 1'b1, 5'd10, 5'd4,  5'd10, 64'hB,                  64'h0,                  1'b1, 1'b0, 6'd3};
    tbl[19] = '{1'b1, 1'b0, 5'd0,  64'h0,                  1'b0, 5'd0,  5'd9,  5'd4,  64'h0,                  64'h0,                  1'b0, 1'b0, 6'd0};
    tbl[20] = '{1'b1, 1'b1, 5'd9,  64'h1,                  1'b1, 5'd9,  5'd9,  5'd4,  64'h1,                  64'h0,                  1'b0, 1'b0, 6'd0};
    tbl[21] = '{1'b1, 1'b0, 5'd0,  64'h0,                  1'b0, 5'd0,  5'd9,  5'd9,  64'h1,                  64'h1,                  1'b1, 1'b1, 6'd1};

    // Reset both instances.
    reset = 1'b0; we = 1'b0; wa = '0; wd = '0; rs = 1'b0; rsa = '0; rr = '0;
    b_reset = 1'b0; b_we = 1'b0; b_wa = '0; b_wd = '0; b_rs = 1'b0; b_rsa = '0; b_rr = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Every address reads zero and not pending after reset.
    for (int a = 0; a < 32; a++) begin
      rr[0] = 5'(a);
      rr[1] = 5'(31 - a);
      #1;
      chk($sformatf("rst_d0[%0d]", a), rd[0], 64'h0);
      chk($sformatf("rst_d1[%0d]", 31 - a), rd[1], 64'h0);
      chk($sformatf("rst_p[%0d]", a), {62'h0, rp}, 64'h0);
    end
    chk("rst_cnt", {58'h0, cnt}, 64'h0);

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      reset  = tbl[i].rst;
      we     = tbl[i].we;
      wa     = tbl[i].wa;
      wd     = tbl[i].wd;
      rs     = tbl[i].rs;
      rsa    = tbl[i].rsa;
      rr[0]  = tbl[i].a0;
      rr[1]  = tbl[i].a1;
      #1;
      chk($sformatf("v%0d.d0", i), rd[0], tbl[i].d0);
      chk($sformatf("v%0d.d1", i), rd[1], tbl[i].d1);
      chk($sformatf("v%0d.p0", i), {63'h0, rp[0]}, {63'h0, tbl[i].p0});
      chk($sformatf("v%0d.p1", i), {63'h0, rp[1]}, {63'h0, tbl[i].p1});
      chk($sformatf("v%0d.cnt", i), {58'h0, cnt}, {58'h0, tbl[i].cnt});
    end
    @(negedge clk);
    we = 1'b0; rs = 1'b0;

    // Depth-6 instance: out-of-range addresses and the top index as a normal register.
    b_reset = 1'b1;
    b_we = 1'b1; b_wa = 3'd7; b_wd = 16'hAAAA;
    b_rr[0] = 3'd7; b_rr[1] = 3'd6;
    #1;
    chk("b_oor_bypass_d0", {48'h0, b_rd[0]}, 64'h0);
    chk("b_oor_d1", {48'h0, b_rd[1]}, 64'h0);
    chk("b_oor_p", {62'h0, b_rp}, 64'h0);

    @(negedge clk);
    b_we = 1'b0; b_rs = 1'b1; b_rsa = 3'd6;
    #1;
    chk("b_oor_wr_ignored", {48'h0, b_rd[0]}, 64'h0);

    @(negedge clk);
    b_rs = 1'b1; b_rsa = 3'd7;
    #1;
    chk("b_rs6_cnt", {61'h0, b_cnt}, 64'h0);

    @(negedge clk);
    b_rs = 1'b0;
    b_we = 1'b1; b_wa = 3'd5; b_wd = 16'h1234;
    b_rr[0] = 3'd5; b_rr[1] = 3'd0;
    #1;
    chk("b_rs7_cnt", {61'h0, b_cnt}, 64'h0);
    chk("b_r5_bypass", {48'h0, b_rd[0]}, 64'h1234);
    chk("b_r0", {48'h0, b_rd[1]}, 64'h0);

    @(negedge clk);
    b_we = 1'b0; b_rs = 1'b1; b_rsa = 3'd5;
    #1;
    chk("b_r5_stored", {48'h0, b_rd[0]}, 64'h1234);
    chk("b_r5_rs_not_comb", {63'h0, b_rp[0]}, 64'h0);

    @(negedge clk);
    b_rs = 1'b0;
    b_rr[0] = 3'd5; b_rr[1] = 3'd6;
    #1;
    chk("b_r5_pend", {63'h0, b_rp[0]}, 64'h1);
    chk("b_cnt1", {61'h0, b_cnt}, 64'h1);
    chk("b_r6_oor", {48'h0, b_rd[1]}, 64'h0);
    chk("b_r6_oor_p", {63'h0, b_rp[1]}, 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
